// File: rtl/memory_port_arbiter_if.sv
// Fetch/MEM request handshakes and the asynchronous SRAM pin group
// shared by the memory port arbiter.
interface memory_port_arbiter_if #(
  parameter int unsigned SRAM_ADDR_WIDTH = 18
);
  // Instruction-fetch requester
  logic                       if_req;
  logic [15:0]                if_addr;
  logic [15:0]                if_rdata;
  logic                       if_ack;

  // MEM-stage requester
  logic                       mem_req;
  logic                       mem_we;
  logic [15:0]                mem_addr;
  logic [15:0]                mem_wdata;
  logic [15:0]                mem_rdata;
  logic                       mem_ack;

  // Status and SRAM pins
  logic                       busy;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic [15:0]                sram_dq_out;
  logic                       sram_dq_oe;
  logic [15:0]                sram_dq_in;
  logic                       sram_ce_n;
  logic                       sram_oe_n;
  logic                       sram_we_n;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_dq_in,
    output if_rdata, if_ack, mem_rdata, mem_ack, busy,
           sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_dq_in,
    input  if_rdata, if_ack, mem_rdata, mem_ack, busy,
           sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Arbitrates fetch and MEM word requests onto one asynchronous SRAM with registered strobes.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on ties instead of fixed data priority.
module memory_port_arbiter #(
  parameter int unsigned SRAM_ADDR_WIDTH = 18,
  parameter int unsigned WAIT_CYCLES     = 1
) (
  input logic                  clock,
  input logic                  reset,
  memory_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_e;

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_CYCLES);

  state_e                     state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic                       owner_mem_q, owner_mem_d;
  logic                       we_q, we_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]                wdata_q, wdata_d;
  logic [15:0]                if_rdata_q, if_rdata_d;
  logic [15:0]                mem_rdata_q, mem_rdata_d;
  logic                       if_ack_q, if_ack_d;
  logic                       mem_ack_q, mem_ack_d;
  logic                       busy_q, busy_d;
  logic                       ce_n_q, ce_n_d;
  logic                       oe_n_q, oe_n_d;
  logic                       we_n_q, we_n_d;
  logic                       dq_oe_q, dq_oe_d;
  logic                       grant_mem, grant_if;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remembers who won the previous grant; a tie goes to the other side.
  logic last_mem_q;

  assign grant_mem = bus.mem_req && !(bus.if_req && last_mem_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_mem_q <= 1'b0;
    end else if (state_q == IDLE && (bus.mem_req || bus.if_req)) begin
      last_mem_q <= grant_mem;
    end
  end
`else
  assign grant_mem = bus.mem_req;
`endif

  assign grant_if = bus.if_req && !grant_mem;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_mem_d = owner_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_mem || grant_if) begin
          owner_mem_d = grant_mem;
          we_d        = grant_mem && bus.mem_we;
          addr_d      = SRAM_ADDR_WIDTH'(grant_mem ? bus.mem_addr : bus.if_addr);
          if (we_d) wdata_d = bus.mem_wdata;
          cnt_d       = WAIT_CNT;
          state_d     = we_d ? SETUP : ACCESS;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (we_q) begin
          state_d = HOLD;
        end else begin
          state_d = DONE;
          if (owner_mem_q) begin
            mem_rdata_d = bus.sram_dq_in;
            mem_ack_d   = 1'b1;
          end else begin
            if_rdata_d = bus.sram_dq_in;
            if_ack_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        state_d   = DONE;
        mem_ack_d = owner_mem_q;
        if_ack_d  = !owner_mem_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are derived from the next state so the pins are glitch-free register outputs.
    busy_d  = (state_d != IDLE);
    ce_n_d  = !(state_d inside {SETUP, ACCESS, HOLD});
    oe_n_d  = !(state_d == ACCESS && !we_d);
    we_n_d  = !(state_d == ACCESS && we_d);
    dq_oe_d = we_d && (state_d inside {SETUP, ACCESS, HOLD});
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      if_rdata_q  <= 16'h0000;
      mem_rdata_q <= 16'h0000;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_mem_q <= owner_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      busy_q      <= busy_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  assign bus.if_rdata    = if_rdata_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.mem_ack     = mem_ack_q;
  assign bus.busy        = busy_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = wdata_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_ce_n   = ce_n_q;
  assign bus.sram_oe_n   = oe_n_q;
  assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: directed protocol steps plus randomized
// traffic checked against a word-array model of the SRAM contents.
module tb_memory_port_arbiter;

  localparam int W = 1;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  memory_port_arbiter_if #(.SRAM_ADDR_WIDTH(18)) bus  ();
  memory_port_arbiter_if #(.SRAM_ADDR_WIDTH(18)) bus0 ();

  memory_port_arbiter #(.SRAM_ADDR_WIDTH(18), .WAIT_CYCLES(W)) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  memory_port_arbiter #(.SRAM_ADDR_WIDTH(18), .WAIT_CYCLES(0)) u_dut0 (
    .clock(clock),
    .reset(reset),
    .bus  (bus0.slave)
  );

  // Simple SRAM: combinational read, write sampled while we_n is low.
  logic [15:0] sram    [256];
  logic [15:0] ref_mem [256];
  logic [15:0] sram0_word;

  assign bus.sram_dq_in  = sram[bus.sram_addr[7:0]];
  assign bus0.sram_dq_in = sram0_word;

  always @(posedge clock) begin
    if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe)
      sram[bus.sram_addr[7:0]] <= bus.sram_dq_out;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete access on the W-cycle port, profiled cycle by cycle after the sampling edge.
  task automatic run_access(input string tag, input bit is_mem, input bit we,
                            input logic [15:0] addr, input logic [15:0] wdata);
    int          ce_low, oe_low, we_low, dq_oe_hi, busy_hi, ack_at, first_we, bad_ack, dq_bad;
    logic [15:0] rd;
    logic [17:0] addr_seen;
    ce_low = 0; oe_low = 0; we_low = 0; dq_oe_hi = 0; busy_hi = 0;
    ack_at = -1; first_we = -1; bad_ack = 0; dq_bad = 0;
    rd = 16'h0000; addr_seen = 18'h3ffff;
    @(negedge clock);
    if (is_mem) begin
      bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_addr = addr; bus.mem_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int k = 1; k <= 20 && ack_at < 0; k++) begin
      @(negedge clock);
      if (!bus.sram_ce_n) begin ce_low++; addr_seen = bus.sram_addr; end
      if (!bus.sram_oe_n) oe_low++;
      if (!bus.sram_we_n) begin
        we_low++;
        if (first_we < 0) first_we = k;
        if (bus.sram_dq_out !== wdata) dq_bad++;
      end
      if (bus.sram_dq_oe) dq_oe_hi++;
      if (bus.busy) busy_hi++;
      if (is_mem ? bus.if_ack : bus.mem_ack) bad_ack++;
      if (is_mem ? bus.mem_ack : bus.if_ack) begin
        ack_at = k;
        rd = is_mem ? bus.mem_rdata : bus.if_rdata;
        bus.mem_req = 1'b0; bus.if_req = 1'b0;
      end
    end
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
    check({tag, " ack latency"},   32'(ack_at),   32'(we ? W + 4 : W + 2));
    check({tag, " busy cycles"},   32'(busy_hi),  32'(we ? W + 4 : W + 2));
    check({tag, " ce_n low"},      32'(ce_low),   32'(we ? W + 3 : W + 1));
    check({tag, " oe_n low"},      32'(oe_low),   32'(we ? 0 : W + 1));
    check({tag, " we_n low"},      32'(we_low),   32'(we ? W + 1 : 0));
    check({tag, " dq_oe cycles"},  32'(dq_oe_hi), 32'(we ? W + 3 : 0));
    check({tag, " sram_addr"},     32'(addr_seen), 32'({2'b00, addr}));
    check({tag, " foreign ack"},   32'(bad_ack),  32'(0));
    if (we) begin
      check({tag, " we_n first low"}, 32'(first_we), 32'(2));
      check({tag, " dq_out"},         32'(dq_bad),   32'(0));
      ref_mem[addr[7:0]] = wdata;
    end else begin
      check({tag, " rdata"}, 32'(rd), 32'(ref_mem[addr[7:0]]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          order [$];
    int          fetch_acks, double_acks, late_acks, kind;
    logic [15:0] a, d;

    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom);
      sram[i] = d; ref_mem[i] = d;
    end
    sram[8'h10] = 16'h4A21; ref_mem[8'h10] = 16'h4A21;

    bus.if_req = 1'b0;  bus.if_addr = 16'h0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    bus.mem_addr = 16'h0; bus.mem_wdata = 16'h0;
    bus0.if_req = 1'b0; bus0.if_addr = 16'h0; bus0.mem_req = 1'b0; bus0.mem_we = 1'b0;
    bus0.mem_addr = 16'h0; bus0.mem_wdata = 16'h0;
    sram0_word = 16'h0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset busy",      32'(bus.busy),        32'(0));
    check("reset ce_n",      32'(bus.sram_ce_n),   32'(1));
    check("reset oe_n",      32'(bus.sram_oe_n),   32'(1));
    check("reset we_n",      32'(bus.sram_we_n),   32'(1));
    check("reset dq_oe",     32'(bus.sram_dq_oe),  32'(0));
    check("reset if_ack",    32'(bus.if_ack),      32'(0));
    check("reset mem_ack",   32'(bus.mem_ack),     32'(0));
    check("reset sram_addr", 32'(bus.sram_addr),   32'(0));
    check("reset dq_out",    32'(bus.sram_dq_out), 32'(0));
    check("reset if_rdata",  32'(bus.if_rdata),    32'(0));
    check("reset mem_rdata", 32'(bus.mem_rdata),   32'(0));
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Directed reads and writes
    run_access("fetch read 0010", 1'b0, 1'b0, 16'h0010, 16'h0000);
    check("if_rdata held", 32'(bus.if_rdata), 32'(16'h4A21));
    run_access("mem write 8000", 1'b1, 1'b1, 16'h8000, 16'hBEEF);
    run_access("mem readback 8000", 1'b1, 1'b0, 16'h8000, 16'h0000);

    // W=0 read with the request dropped during the single ACCESS cycle
    sram0_word = 16'h5A3C;
    @(negedge clock);
    bus0.mem_req = 1'b1; bus0.mem_we = 1'b0; bus0.mem_addr = 16'h0033;
    @(negedge clock);
    check("w0 access oe_n", 32'(bus0.sram_oe_n), 32'(0));
    check("w0 access ce_n", 32'(bus0.sram_ce_n), 32'(0));
    check("w0 access addr", 32'(bus0.sram_addr), 32'(18'h00033));
    bus0.mem_req = 1'b0;
    @(negedge clock);
    check("w0 mem_ack",   32'(bus0.mem_ack),   32'(1));
    check("w0 mem_rdata", 32'(bus0.mem_rdata), 32'(16'h5A3C));
    check("w0 done ce_n", 32'(bus0.sram_ce_n), 32'(1));
    @(negedge clock);
    check("w0 ack width", 32'(bus0.mem_ack),   32'(0));
    check("w0 idle busy", 32'(bus0.busy),      32'(0));

    // Both requesters held continuously from a fresh reset
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 16'h0005;
    bus.if_req  = 1'b1; bus.if_addr = 16'h0006;
    fetch_acks = 0; double_acks = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.mem_ack && bus.if_ack) double_acks++;
      if (bus.mem_ack) order.push_back(1);
      if (bus.if_ack) begin order.push_back(0); fetch_acks++; end
    end
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
    repeat (10) @(negedge clock);
    check("contention double ack", 32'(double_acks), 32'(0));
    check("contention ack count",  32'(order.size() >= 4), 32'(1));
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check($sformatf("rr ack order %0d", i), 32'(i < order.size() ? order[i] : 2), 32'(i % 2 == 0));
`else
      check($sformatf("fixed ack order %0d", i), 32'(i < order.size() ? order[i] : 2), 32'(1));
`endif
    end
`ifndef MEM_ARB_ROUND_ROBIN_EN
    check("fetch starved", 32'(fetch_acks), 32'(0));
`endif
    check("contention idle", 32'(bus.busy), 32'(0));

    // Reset asserted during the write ACCESS phase
    @(negedge clock);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 16'h0040; bus.mem_wdata = 16'h1234;
    repeat (2) @(negedge clock);
    check("abort pre we_n", 32'(bus.sram_we_n), 32'(0));
    reset = 1'b0;
    #1;
    check("abort we_n",  32'(bus.sram_we_n),  32'(1));
    check("abort ce_n",  32'(bus.sram_ce_n),  32'(1));
    check("abort dq_oe", 32'(bus.sram_dq_oe), 32'(0));
    check("abort busy",  32'(bus.busy),       32'(0));
    bus.mem_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    late_acks = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.mem_ack || bus.if_ack) late_acks++;
    end
    check("abort no ack", 32'(late_acks), 32'(0));
    run_access("post-reset read 0020", 1'b0, 1'b0, 16'h0020, 16'h0000);

    // Randomized single-requester traffic
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 2));
      a    = 16'($urandom);
      d    = 16'($urandom);
      run_access($sformatf("rand%0d", n), kind != 0, kind == 2, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
